// File: rtl/ele_call_panel.sv
// Call-register front end for ele_ctrl: latches button presses, picks SCAN-ordered
// targets, presents them as a held one-hot req and times the door after each stop.
module ele_call_panel #(
    parameter int unsigned DOOR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [1:0] curr_flr,
    input  logic       moving,
    output logic [3:0] req,
    output logic [3:0] pending,
    output logic       door_open,
    output logic       busy
);

    localparam int unsigned NUM_FLR = 4;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_DOOR  = 2'd2;

    logic [1:0]       state, state_n;
    logic [1:0]       target, target_n;
    logic             dir, dir_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       btn_q;

    logic [3:0] press;
    logic [3:0] clr;
    logic [3:0] here_calls;
    logic [3:0] pending_n;
    logic       above_any, below_any;
    logic [1:0] above_tgt, below_tgt;

    // Nearest pending floor above (lowest) and below (highest) the car.
    always_comb begin
        above_any = 1'b0;
        below_any = 1'b0;
        above_tgt = 2'd0;
        below_tgt = 2'd0;
        for (int i = 0; i < NUM_FLR; i++) begin
            if (pending[i] && (2'(i) > curr_flr) && !above_any) begin
                above_any = 1'b1;
                above_tgt = 2'(i);
            end
            if (pending[i] && (2'(i) < curr_flr)) begin
                below_any = 1'b1;
                below_tgt = 2'(i);
            end
        end
    end

    always_comb begin
        press      = btn & ~btn_q;
        here_calls = press | pending;
        state_n    = state;
        target_n   = target;
        dir_n      = dir;
        cnt_n      = cnt;
        clr        = 4'b0000;
        case (state)
            S_IDLE: begin
                if (here_calls[curr_flr] && !moving) begin
                    clr     = 4'b0001 << curr_flr;
                    cnt_n   = DOOR_LOAD;
                    state_n = S_DOOR;
                end else if (dir) begin
                    if (above_any) begin
                        target_n = above_tgt;
                        state_n  = S_SERVE;
                    end else if (below_any) begin
                        dir_n    = 1'b0;
                        target_n = below_tgt;
                        state_n  = S_SERVE;
                    end
                end else begin
                    if (below_any) begin
                        target_n = below_tgt;
                        state_n  = S_SERVE;
                    end else if (above_any) begin
                        dir_n    = 1'b1;
                        target_n = above_tgt;
                        state_n  = S_SERVE;
                    end
                end
            end
            S_SERVE: begin
                if ((curr_flr == target) && !moving) begin
                    clr     = 4'b0001 << target;
                    cnt_n   = DOOR_LOAD;
                    state_n = S_DOOR;
                end
            end
            S_DOOR: begin
                // A press at the current floor holds the door instead of queueing a call.
                if (press[curr_flr]) begin
                    clr   = 4'b0001 << curr_flr;
                    cnt_n = DOOR_LOAD;
                end else begin
                    if (cnt == CNT_W'(1)) begin
                        state_n = S_IDLE;
                    end
                    cnt_n = (cnt == '0) ? '0 : cnt - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        pending_n = (pending | press) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            target    <= 2'd0;
            dir       <= 1'b1;
            cnt       <= '0;
            btn_q     <= 4'b0000;
            pending   <= 4'b0000;
            req       <= 4'b0000;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            dir       <= dir_n;
            cnt       <= cnt_n;
            btn_q     <= btn;
            pending   <= pending_n;
            req       <= (state_n == S_SERVE) ? (4'b0001 << target_n) : 4'b0000;
            door_open <= (state_n == S_DOOR);
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule
